// File: rtl/obi_rr_arbiter.sv
// obi_rr_arbiter: round-robin OBI arbiter with in-order response routing and address-window error responses
module obi_rr_arbiter #(
  parameter int          NUM_MASTERS     = 2,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_5000,
  parameter logic [31:0] LAST_ADDR       = 32'h0000_9000
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_MASTERS-1:0]    m_req_i,
  output logic [NUM_MASTERS-1:0]    m_gnt_o,
  input  logic [NUM_MASTERS*32-1:0] m_addr_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [NUM_MASTERS*4-1:0]  m_be_i,
  input  logic [NUM_MASTERS*32-1:0] m_wdata_i,
  output logic [NUM_MASTERS-1:0]    m_rvalid_o,
  output logic [31:0]               m_rdata_o,
  output logic                      m_err_o,
  output logic                      s_req_o,
  input  logic                      s_gnt_i,
  output logic [31:0]               s_addr_o,
  output logic                      s_we_o,
  output logic [3:0]                s_be_o,
  output logic [31:0]               s_wdata_o,
  input  logic                      s_rvalid_i,
  input  logic [31:0]               s_rdata_i,
  input  logic                      s_err_i
);
  localparam int IW = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1;
  localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic [IW-1:0] rr, locked_id, err_id, arb_id, idx, winner, head;
  logic          locked, err_pend, found;
  logic [IW-1:0] fifo [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   w_addr;
  logic          in_range, full, empty, fwd, err_acc, pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Round-robin search starting just after the last-served manager
  always_comb begin
    arb_id = rr;
    idx = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = IW'((int'(rr) + k) % NUM_MASTERS);
      if (!found && m_req_i[idx]) begin
        arb_id = idx;
        found = 1'b1;
      end
    end
  end

  // A manager left waiting on s_gnt_i keeps the port until it is granted
  assign winner   = locked ? locked_id : arb_id;
  assign w_addr   = m_addr_i[32*winner +: 32];
  assign in_range = (w_addr >= BASE_ADDR) && (w_addr < LAST_ADDR);
  assign full     = count == CW'(MAX_OUTSTANDING);
  assign empty    = count == '0;
  assign head     = fifo[rd_ptr];

  assign s_req_o   = rst_ni && m_req_i[winner] && in_range && !full && !err_pend;
  assign s_addr_o  = s_req_o ? w_addr : '0;
  assign s_we_o    = s_req_o && m_we_i[winner];
  assign s_be_o    = s_req_o ? m_be_i[4*winner +: 4] : '0;
  assign s_wdata_o = s_req_o ? m_wdata_i[32*winner +: 32] : '0;

  // Out-of-window requests are answered locally, only once nothing is in flight
  assign fwd     = s_req_o && s_gnt_i;
  assign err_acc = rst_ni && m_req_i[winner] && !in_range && empty && !err_pend;
  assign pop     = rst_ni && s_rvalid_i && !empty;

  assign m_gnt_o    = (fwd || err_acc) ? NUM_MASTERS'(1) << winner : '0;
  assign m_rvalid_o = pop ? NUM_MASTERS'(1) << head : (rst_ni && err_pend) ? NUM_MASTERS'(1) << err_id : '0;
  assign m_rdata_o  = pop ? s_rdata_i : '0;
  assign m_err_o    = pop ? s_err_i : rst_ni && err_pend;

  // Arbitration state, ID FIFO of forwarded transactions and pending local error
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr <= '0;
      locked <= 1'b0;
      locked_id <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      err_pend <= 1'b0;
      err_id <= '0;
    end else begin
      if (fwd || err_acc) rr <= winner;
      locked <= s_req_o && !s_gnt_i;
      if (s_req_o && !s_gnt_i) locked_id <= winner;
      if (fwd) begin
        fifo[wr_ptr] <= winner;
        wr_ptr <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(fwd) - CW'(pop);
      err_pend <= err_acc;
      if (err_acc) err_id <= winner;
    end
  end

  // A response with nothing outstanding means the subordinate is out of step
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(s_rvalid_i && empty));
  assert property (@(posedge clk_i) $onehot0(m_gnt_o) && $onehot0(m_rvalid_o));
endmodule
